// File: rtl/cdb_pkg.sv
// Shared types for the common-data-bus writeback path.
// One result bundle is a destination tag plus its value.
package cdb_pkg;

  localparam int NUM_WB_LANES = 3;
  localparam int VREG_W = 5;

  typedef struct packed {
    logic [VREG_W-1:0] vregid;
    logic [31:0]       val;
  } wb_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-source result buffer; a push to a full FIFO is dropped
// unless the same edge also pops it.
module wb_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  wb_t         din,
  output wb_t         dout,
  output logic        empty,
  output logic        full,
  output logic [AW:0] count
);

  wb_t           mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    rd_en    = pop && !empty;
    wr_en    = push && (!full || rd_en);
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(rd_en);
    count_d  = count_q + (AW+1)'(wr_en)
             - (AW+1)'(rd_en);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Common data bus: buffers FU results per source and broadcasts
// up to three per cycle, round-robin across sources.
module writeback_arbiter
  import cdb_pkg::*;
#(
  parameter int NSRC  = 4,
  parameter int DEPTH = 4,
  parameter int SLACK = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [NSRC-1:0]        src_valid,
  input  logic [VREG_W*NSRC-1:0] src_vregid,
  input  logic [32*NSRC-1:0]     src_val,
  output logic [NSRC-1:0]        src_busy,
  output logic                   writeback1_en,
  output logic [VREG_W-1:0]      writeback1_vregid,
  output logic [31:0]            writeback1_val,
  output logic                   writeback2_en,
  output logic [VREG_W-1:0]      writeback2_vregid,
  output logic [31:0]            writeback2_val,
  output logic                   writeback3_en,
  output logic [VREG_W-1:0]      writeback3_vregid,
  output logic [31:0]            writeback3_val,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  wb_t                    din  [NSRC];
  wb_t                    head [NSRC];
  logic [AW:0]            count [NSRC];
  logic [NSRC-1:0]        empty, full, grant;

  wb_t [NUM_WB_LANES-1:0] wb_q, wb_d;
  logic [NUM_WB_LANES-1:0] en_q, en_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]          last;
  logic                   overflow_q, overflow_d;
  int                     nl, idx;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign din[i].vregid = src_vregid[VREG_W*i +: VREG_W];
    assign din[i].val    = src_val[32*i +: 32];
    assign src_busy[i]   = (DEPTH - int'(count[i])) <= SLACK;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (src_valid[i]),
      .pop   (grant[i]),
      .din   (din[i]),
      .dout  (head[i]),
      .empty (empty[i]),
      .full  (full[i]),
      .count (count[i])
    );
  end

  // Rotate from rr_ptr; first three non-empty heads take lanes 1..3.
  always_comb begin
    grant = '0;
    wb_d  = wb_q;
    en_d  = '0;
    last  = rr_ptr_q;
    nl    = 0;
    idx   = 0;
    for (int j = 0; j < NSRC; j++) begin
      idx = (int'(rr_ptr_q) + j) % NSRC;
      if (!empty[idx] && nl < NUM_WB_LANES) begin
        grant[idx] = 1'b1;
        wb_d[nl]   = head[idx];
        en_d[nl]   = 1'b1;
        last       = PW'(idx);
        nl         = nl + 1;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (|grant) rr_ptr_d = PW'((int'(last) + 1) % NSRC);
    overflow_d = overflow_q
               | (|(src_valid & full & ~grant));
    if (flush) begin
      en_d       = '0;
      rr_ptr_d   = '0;
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_q       <= '0;
      en_q       <= '0;
      rr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wb_q       <= wb_d;
      en_q       <= en_d;
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign writeback1_en     = en_q[0];
  assign writeback1_vregid = wb_q[0].vregid;
  assign writeback1_val    = wb_q[0].val;
  assign writeback2_en     = en_q[1];
  assign writeback2_vregid = wb_q[1].vregid;
  assign writeback2_val    = wb_q[1].val;
  assign writeback3_en     = en_q[2];
  assign writeback3_vregid = wb_q[2].vregid;
  assign writeback3_val    = wb_q[2].val;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter.
// Expected broadcasts are queued at stimulus time and checked by a monitor.
module tb_writeback_arbiter;
  import cdb_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   src_valid = '0;
  logic [19:0]  src_vregid = '0;
  logic [127:0] src_val = '0;
  logic [3:0]   src_busy;
  logic         writeback1_en, writeback2_en, writeback3_en;
  logic [4:0]   writeback1_vregid, writeback2_vregid;
  logic [4:0]   writeback3_vregid;
  logic [31:0]  writeback1_val, writeback2_val, writeback3_val;
  logic         overflow;

  writeback_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .src_valid         (src_valid),
    .src_vregid        (src_vregid),
    .src_val           (src_val),
    .src_busy          (src_busy),
    .writeback1_en     (writeback1_en),
    .writeback1_vregid (writeback1_vregid),
    .writeback1_val    (writeback1_val),
    .writeback2_en     (writeback2_en),
    .writeback2_vregid (writeback2_vregid),
    .writeback2_val    (writeback2_val),
    .writeback3_en     (writeback3_en),
    .writeback3_vregid (writeback3_vregid),
    .writeback3_val    (writeback3_val),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       en;
    logic [2:0][4:0]  v;
    logic [2:0][31:0] d;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  bit   sb_on = 1'b1;
  bit   tal_on = 1'b0;
  int   win = 0;
  int   tally [4];
  int   miss [4];
  int   maxmiss [4];

  logic [2:0]       m_en;
  logic [2:0][4:0]  ov;
  logic [2:0][31:0] od;
  logic [3:0]       got;
  exp_t             e;

  assign m_en = {writeback3_en, writeback2_en, writeback1_en};
  assign ov = {writeback3_vregid, writeback2_vregid,
               writeback1_vregid};
  assign od = {writeback3_val, writeback2_val, writeback1_val};

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && tal_on) begin
      if (m_en != 3'b000 && win < 20) begin
        win++;
        got = '0;
        for (int l = 0; l < 3; l++)
          if (m_en[l] && ov[l] < 5'd4) got[ov[l][1:0]] = 1'b1;
        for (int s = 0; s < 4; s++) begin
          if (got[s]) begin
            tally[s]++;
            miss[s] = 0;
          end else begin
            miss[s]++;
            if (miss[s] > maxmiss[s]) maxmiss[s] = miss[s];
          end
        end
      end
    end else if (rst && sb_on && m_en != 3'b000) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got en=%b expected none",
                 m_en);
      end else begin
        e = q.pop_front();
        chk("sb_en", 64'(m_en), 64'(e.en));
        for (int l = 0; l < 3; l++) begin
          if (e.en[l]) begin
            chk($sformatf("sb_lane%0d_vregid", l + 1),
                64'(ov[l]), 64'(e.v[l]));
            chk($sformatf("sb_lane%0d_val", l + 1),
                64'(od[l]), 64'(e.d[l]));
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cyc(input logic [3:0] v, input logic [19:0] id,
                     input logic [127:0] d);
    src_valid  = v;
    src_vregid = id;
    src_val    = d;
    @(posedge clk);
    #1;
    src_valid  = '0;
  endtask

  task automatic expect_rec(input logic [2:0] en,
                            input logic [4:0] v1, v2, v3,
                            input logic [31:0] d1, d2, d3);
    exp_t x;
    x.en = en;
    x.v  = {v3, v2, v1};
    x.d  = {d3, d2, d1};
    q.push_back(x);
  endtask

  task automatic sb_drain(input string name);
    idle(6);
    chk(name, 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle(2);
    rst = 1'b1;
    chk("rst_en", 64'(m_en), 64'd0);
    chk("rst_vregid", 64'(ov), 64'd0);
    chk("rst_val", 64'(|od), 64'd0);
    chk("rst_busy", 64'(src_busy), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);

    // single result from source 2
    expect_rec(3'b001, 5'd7, 5'd0, 5'd0, 32'h12345678, 0, 0);
    cyc(4'b0100, {5'd0, 5'd7, 5'd0, 5'd0},
        {32'h0, 32'h12345678, 64'h0});
    chk("t1_not_early", 64'(writeback1_en), 64'd0);
    idle(1);
    chk("t1_latency", 64'(writeback1_en), 64'd1);
    sb_drain("t1_sb_empty");

    // four at once, then again to confirm rr_ptr came back to 0
    do_reset();
    expect_rec(3'b111, 5'd1, 5'd2, 5'd3,
               32'hA0000001, 32'hA0000002, 32'hA0000003);
    expect_rec(3'b001, 5'd4, 5'd0, 5'd0, 32'hA0000004, 0, 0);
    cyc(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},
        {32'hA0000004, 32'hA0000003, 32'hA0000002, 32'hA0000001});
    idle(3);
    expect_rec(3'b111, 5'd5, 5'd6, 5'd7,
               32'hB0000005, 32'hB0000006, 32'hB0000007);
    expect_rec(3'b001, 5'd8, 5'd0, 5'd0, 32'hB0000008, 0, 0);
    cyc(4'b1111, {5'd8, 5'd7, 5'd6, 5'd5},
        {32'hB0000008, 32'hB0000007, 32'hB0000006, 32'hB0000005});
    sb_drain("t2_sb_empty");

    // all sources push for 20 cycles: fairness, busy, overflow
    do_reset();
    sb_on  = 1'b0;
    win    = 0;
    for (int s = 0; s < 4; s++) begin
      tally[s]   = 0;
      miss[s]    = 0;
      maxmiss[s] = 0;
    end
    tal_on = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc(4'b1111, {5'd3, 5'd2, 5'd1, 5'd0},
          {32'h33, 32'h22, 32'h11, 32'h00});
      if (k == 1) chk("t4_busy_e1", 64'(src_busy), 64'h0);
      if (k == 2) chk("t4_busy_e2", 64'(src_busy), 64'h8);
      if (k == 3) chk("t4_busy_e3", 64'(src_busy), 64'hC);
      if (k == 5) chk("t4_busy_e5", 64'(src_busy), 64'hF);
      if (k == 13) chk("t4_ovf_before", 64'(overflow), 64'd0);
      if (k == 14) chk("t4_ovf_set", 64'(overflow), 64'd1);
    end
    idle(12);
    tal_on = 1'b0;
    chk("t3_window", 64'(win), 64'd20);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("t3_grants_src%0d", s),
          64'(tally[s]), 64'd15);
      chk($sformatf("t3_maxwait_src%0d", s),
          64'(maxmiss[s] <= 2), 64'd1);
    end
    chk("t4_ovf_sticky", 64'(overflow), 64'd1);
    chk("t4_busy_drained", 64'(src_busy), 64'd0);
    do_reset();
    chk("t4_ovf_reset", 64'(overflow), 64'd0);
    sb_on = 1'b1;

    // flush with three buffered entries and a same-cycle push
    cyc(4'b0111, {5'd0, 5'd12, 5'd11, 5'd10},
        {32'h0, 32'hC3, 32'hC2, 32'hC1});
    flush = 1'b1;
    cyc(4'b1000, {5'd13, 15'd0}, {32'hC4, 96'h0});
    flush = 1'b0;
    chk("t5_flush_en", 64'(m_en), 64'd0);
    chk("t5_flush_busy", 64'(src_busy), 64'd0);
    idle(2);
    chk("t5_after_flush_en", 64'(m_en), 64'd0);
    expect_rec(3'b001, 5'd14, 5'd0, 5'd0, 32'hD0D0D0D0, 0, 0);
    cyc(4'b0010, {10'd0, 5'd14, 5'd0},
        {64'h0, 32'hD0D0D0D0, 32'h0});
    chk("t5_not_early", 64'(writeback1_en), 64'd0);
    idle(1);
    chk("t5_latency", 64'(writeback1_en), 64'd1);
    sb_drain("t5_sb_empty");

    // reset held two cycles mid-burst
    cyc(4'b1111, {5'd18, 5'd17, 5'd16, 5'd15},
        {32'hE4, 32'hE3, 32'hE2, 32'hE1});
    rst = 1'b0;
    idle(1);
    chk("t6_rst_en", 64'(m_en), 64'd0);
    chk("t6_rst_busy", 64'(src_busy), 64'd0);
    idle(1);
    rst = 1'b1;
    chk("t6_rst_vregid", 64'(ov), 64'd0);
    chk("t6_rst_val", 64'(|od), 64'd0);
    idle(2);
    chk("t6_no_leftover", 64'(m_en), 64'd0);
    expect_rec(3'b001, 5'd19, 5'd0, 5'd0, 32'hF00DF00D, 0, 0);
    cyc(4'b0001, {15'd0, 5'd19}, {96'h0, 32'hF00DF00D});
    chk("t6_not_early", 64'(writeback1_en), 64'd0);
    idle(1);
    chk("t6_latency", 64'(writeback1_en), 64'd1);
    sb_drain("t6_sb_empty");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
